// File: rtl/lsu_defs.sv
// lsu_defs: shared funct3 codes, FSM state encoding and word width for the load/store unit
package lsu_defs;
  localparam int WORD_W = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU;
  endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane select; word/addr/funct3/wdata in, extended load_val and merged store_word out
module lsu_byte_lane
  import lsu_defs::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  input  logic [15:0]       wdata,
  output logic [WORD_W-1:0] load_val,
  output logic [WORD_W-1:0] store_word
);
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign sh_b   = {addr, 3'b000};
  assign sh_h   = {addr[1], 4'b0000};
  assign lane_b = word[sh_b +: 8];
  assign lane_h = word[sh_h +: 16];
  assign load_val = funct3 == F3_B  ? {{24{lane_b[7]}}, lane_b} :
                    funct3 == F3_BU ? {24'b0, lane_b} :
                    funct3 == F3_H  ? {{16{lane_h[15]}}, lane_h} :
                    funct3 == F3_HU ? {16'b0, lane_h} : word;
  assign store_word = funct3 == F3_H ? (word & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata} << sh_h) :
                      funct3 == F3_B ? (word & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata[7:0]} << sh_b) : word;
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed core req (req_*) to word memory (mem_*) with RMW sub-word stores, one-cycle resp_* pulse
module lsu_mem_master
  import lsu_defs::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [WORD_W-1:0] mem_rdata
);
  state_t state;
  state_t nxt;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] addr_q;
  logic [15:0] wdata_q;
  logic [WORD_W-1:0] ld_val;
  logic [WORD_W-1:0] st_word;
  logic accept;
  logic misalign;
  logic range_err;
  logic fault;
  assign accept    = state == S_IDLE && req_valid;
  assign misalign  = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                     (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
  assign range_err = {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);
  assign fault     = !f3_legal(req_funct3) || (req_we && req_funct3[2]) || misalign || range_err;
  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_RESP;
  assign mem_wr     = state == S_WR && rst;
  lsu_byte_lane u_lane (
    .word      (mem_rdata),
    .addr      (addr_q),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .load_val  (ld_val),
    .store_word(st_word)
  );
  always_ff @(posedge clk) state <= !rst ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == S_IDLE ? (!req_valid ? S_IDLE :
                             fault ? S_RESP :
                             (req_we && req_funct3 == F3_W) ? S_WR : S_RD) :
          state == S_RD   ? (we_q ? S_WR : S_RESP) :
          state == S_WR   ? S_RESP : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
        if (fault) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          mem_addr <= {2'b00, req_addr[31:2]};
          if (req_we && req_funct3 == F3_W) mem_wdata <= req_wdata;
        end
      end
      if (state == S_RD) begin
        if (we_q) mem_wdata <= st_word;
        else begin
          resp_rdata <= ld_val;
          resp_err   <= 1'b0;
        end
      end
      if (state == S_WR) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed stimulus with a queue-based reference model checked every cycle
module tb_lsu_mem_master;
  logic clk = 0, rst = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_wr;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  typedef struct {logic [31:0] rdata; logic err; int due;} rsp_t;
  typedef struct {logic [31:0] a; logic [31:0] d; int due;} wr_t;
  rsp_t rq[$];
  wr_t wq[$];
  int cyc = 0, checks = 0, failures = 0, last_acc = 0, last_rcyc = 0;
  bit run = 0;
  logic erv, ewr;
  logic [31:0] last_rdata = 0, last_waddr = 0, last_wdata = 0;
  logic last_err = 0;

  lsu_mem_master #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = (mem_addr < 256) ? mem[mem_addr[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_wr && mem_addr < 256) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (run) begin
    erv = rq.size() > 0 && rq[0].due == cyc;
    ewr = wq.size() > 0 && wq[0].due == cyc;
    chk("resp_valid", 32'(resp_valid), 32'(erv));
    chk("mem_wr", 32'(mem_wr), 32'(ewr));
    if (erv) begin
      chk("resp_rdata", resp_rdata, rq[0].rdata);
      chk("resp_err", 32'(resp_err), 32'(rq[0].err));
      chk("ready_in_resp", 32'(req_ready), 32'(0));
      last_rdata = resp_rdata;
      last_err   = resp_err;
      last_rcyc  = cyc;
    end
    if (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    if (ewr) begin
      chk("mem_addr", mem_addr, wq[0].a);
      chk("mem_wdata", mem_wdata, wq[0].d);
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit keep);
    int n, acc, idx, off, lat;
    logic err;
    logic [31:0] rd, nw;
    logic [7:0] by [4];
    logic [15:0] h;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      req_valid = 0;
      return;
    end
    acc = cyc;
    last_acc = acc;
    @(posedge clk); #1;
    if (!keep) req_valid = 0;
    idx = int'(a >> 2);
    off = int'(a % 4);
    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3 >= 4) ||
          ((f3 == 1 || f3 == 5) && (a % 2) != 0) || (f3 == 2 && off != 0) || idx >= 256;
    if (err) begin
      rq.push_back('{32'h0, 1'b1, acc + 1});
      return;
    end
    for (int i = 0; i < 4; i++) by[i] = ref_mem[idx][8*i +: 8];
    if (!we) begin
      rd = ref_mem[idx];
      if (f3 == 0) rd = by[off] >= 128 ? 32'(int'(by[off]) - 256) : 32'(by[off]);
      if (f3 == 4) rd = 32'(by[off]);
      if (f3 == 1 || f3 == 5) begin
        h = {by[off+1], by[off]};
        rd = (f3 == 1 && h >= 16'd32768) ? 32'(int'(h) - 65536) : 32'(h);
      end
      rq.push_back('{rd, 1'b0, acc + 2});
    end else begin
      if (f3 == 2) begin
        nw = wd;
        lat = 2;
      end else begin
        by[off] = wd[7:0];
        if (f3 == 1) by[off+1] = wd[15:8];
        nw = {by[3], by[2], by[1], by[0]};
        lat = 3;
      end
      ref_mem[idx] = nw;
      wq.push_back('{32'(idx), nw, acc + lat - 1});
      rq.push_back('{32'h0, 1'b0, acc + lat});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() > 0 || wq.size() > 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(rq.size() + wq.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h8899_AABB;
    ref_mem[1] = 32'h8899_AABB;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1;
    run = 1;
    @(posedge clk); #1;
    send(0, 3'b000, 32'h5, 0, 0); drain();
    chk("lb_lit", last_rdata, 32'hFFFF_FFAA);
    chk("lb_err_lit", 32'(last_err), 32'(0));
    chk("lb_latency", 32'(last_rcyc - last_acc), 32'(2));
    send(0, 3'b100, 32'h5, 0, 0); drain();
    chk("lbu_lit", last_rdata, 32'h0000_00AA);
    send(1, 3'b000, 32'h6, 32'h11, 0); drain();
    chk("sb_waddr_lit", last_waddr, 32'h1);
    chk("sb_wdata_lit", last_wdata, 32'h8811_AABB);
    chk("sb_latency", 32'(last_rcyc - last_acc), 32'(3));
    send(0, 3'b010, 32'h4, 0, 0); drain();
    chk("lw_lit", last_rdata, 32'h8811_AABB);
    send(0, 3'b001, 32'h3, 0, 0); drain();
    chk("lh_mis_err_lit", 32'(last_err), 32'(1));
    chk("lh_mis_rdata_lit", last_rdata, 32'h0);
    chk("fault_latency", 32'(last_rcyc - last_acc), 32'(1));
    send(1, 3'b010, 32'h400, 32'h1234_5678, 0); drain();
    chk("sw_range_err_lit", 32'(last_err), 32'(1));
    send(1, 3'b001, 32'h6, 32'hCAFE, 0); drain();
    chk("sh_mem_lit", mem[1], 32'hCAFE_AABB);
    send(0, 3'b001, 32'h6, 0, 0); drain();
    chk("lh_lit", last_rdata, 32'hFFFF_CAFE);
    send(0, 3'b101, 32'h6, 0, 0); drain();
    chk("lhu_lit", last_rdata, 32'h0000_CAFE);
    send(0, 3'b000, 32'h7, 0, 0);
    send(0, 3'b011, 32'h8, 0, 0);
    send(1, 3'b100, 32'h8, 32'h55, 0);
    send(0, 3'b010, 32'h3FC, 0, 0);
    send(0, 3'b101, 32'h3FF, 0, 0);
    send(1, 3'b010, 32'hC, 32'h0BAD_F00D, 0);
    send(0, 3'b000, 32'hE, 0, 0);
    drain();
    chk("sw_lat_check", 32'(rq.size()), 32'(0));
    // store aborted by reset while in WR
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 0;
    req_valid = 0;
    @(negedge clk);
    chk("abort_mem_wr", 32'(mem_wr), 32'(0));
    chk("abort_resp_valid", 32'(resp_valid), 32'(0));
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("abort_mem_unchanged", mem[2], ref_mem[2]);
    send(1, 3'b010, 32'h8, 32'hA1B2_C3D4, 1);
    send(0, 3'b010, 32'h8, 0, 1);
    send(0, 3'b100, 32'hB, 0, 1);
    send(0, 3'b010, 32'h2, 0, 1);
    send(1, 3'b000, 32'h9, 32'h7F, 1);
    send(0, 3'b000, 32'h9, 0, 0);
    drain();
    chk("b2b_last_lit", last_rdata, 32'h0000_007F);
    for (int i = 0; i < 4; i++) chk("final_mem", mem[i], ref_mem[i]);
    chk("final_mem_255", mem[255], ref_mem[255]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
